// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants and state encoding for the serial transmit/receive pair
package serial_pkg;

    localparam int SERIAL_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT,
        ST_ACK   = ACK
    } state_t;

endpackage

// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in serial-out shift register, MSB first, zero fill
module piso_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= data;
        end else if (shift) begin
            shreg_q <= shreg_q << 1;
        end
    end

    assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_byte_tx.sv
// rtl/serial_byte_tx.sv - open-drain data-phase transmitter with ACK sampling
// Optional arbitration-loss detection is compiled in with SERIAL_TX_ARB_LOST_EN.
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             drive_en,
    input  logic             sample_en,
    input  logic             sda_in,
    output logic             sda_out,
    output logic             busy,
    output logic             done,
    output logic             ack,
    output logic             arb_lost
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic            sda_out_q;
    logic            done_q;
    logic            ack_q;
    logic            shreg_msb;
    logic            load_acc;
    logic            shift_en;

    assign load_acc = (state_q == ST_IDLE) && load;
    assign shift_en = (state_q == ST_SHIFT) && drive_en && (count_q != '0);

    piso_shift_register #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .clr   (clr),
        .load  (load_acc),
        .shift (shift_en),
        .data  (data),
        .msb   (shreg_msb)
    );

`ifdef SERIAL_TX_ARB_LOST_EN
    logic arb_lost_q;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            sda_out_q <= 1'b1;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
`ifdef SERIAL_TX_ARB_LOST_EN
            arb_lost_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef SERIAL_TX_ARB_LOST_EN
            arb_lost_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    sda_out_q <= 1'b1;
                    if (load) begin
                        count_q <= CNT_FULL;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // drive_en wins over a simultaneous sample_en
                    if (drive_en) begin
                        if (count_q != '0) begin
                            sda_out_q <= shreg_msb;
                            count_q   <= count_q - CNT_ONE;
                        end else begin
                            sda_out_q <= 1'b1;
                            state_q   <= ST_ACK;
                        end
                    end
`ifdef SERIAL_TX_ARB_LOST_EN
                    else if (sample_en && (count_q < CNT_FULL) && sda_out_q && !sda_in) begin
                        arb_lost_q <= 1'b1;
                        sda_out_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
`endif
                end
                ST_ACK: begin
                    if (sample_en && !drive_en) begin
                        ack_q   <= ~sda_in;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sda_out = sda_out_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign ack     = ack_q;

`ifdef SERIAL_TX_ARB_LOST_EN
    assign arb_lost = arb_lost_q;
`else
    assign arb_lost = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_tx.sv
// tb/tb_serial_byte_tx.sv - randomized self-checking bench for serial_byte_tx
module tb_serial_byte_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [W-1:0] data = '0;
    logic         load = 1'b0;
    logic         drive_en = 1'b0;
    logic         sample_en = 1'b0;
    logic         sda_in = 1'b1;
    logic         sda_out, busy, done, ack, arb_lost;

    int n_tests = 0;
    int n_fail  = 0;

    serial_byte_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .data      (data),
        .load      (load),
        .drive_en  (drive_en),
        .sample_en (sample_en),
        .sda_in    (sda_in),
        .sda_out   (sda_out),
        .busy      (busy),
        .done      (done),
        .ack       (ack),
        .arb_lost  (arb_lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer with random gaps and ignored loads while busy; records the line after each drive_en.
    task automatic run_xfer(input logic [W-1:0] d, input logic ack_lvl, input bit preloaded,
                            output logic [W:0] bits, output int early_done, output logic line_pre,
                            output logic busy_start, output logic done_now, output logic ack_now,
                            output logic busy_now);
        early_done = 0;
        if (!preloaded) begin
            data = d;
            load = 1'b1;
            tick();
            load = 1'b0;
        end
        line_pre   = sda_out;
        busy_start = busy;
        for (int i = 0; i <= W; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                data = W'($urandom);
                load = ($urandom_range(0, 1) == 1);
                tick();
                load = 1'b0;
                if (done) early_done++;
            end
            drive_en = 1'b1;
            tick();
            drive_en = 1'b0;
            bits[W-i] = sda_out;
            if (done) early_done++;
        end
        sda_in    = ack_lvl;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        sda_in    = 1'b1;
        done_now  = done;
        ack_now   = ack;
        busy_now  = busy;
    endtask

    task automatic test_reset();
        logic [W:0] bits;
        int ed;
        logic lp, bs, dn, ak, bn;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        n_tests++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL reset_sda_out: got %b expected 1", sda_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
        n_tests++; if (arb_lost !== 1'b0) begin n_fail++; $display("FAIL reset_arb_lost: got %b expected 0", arb_lost); end

        run_xfer(8'h5A, 1'b0, 1'b0, bits, ed, lp, bs, dn, ak, bn);
        n_tests++; if (ak !== 1'b1) begin n_fail++; $display("FAIL pre_clr_ack: got %b expected 1", ak); end

        data = 8'hA5;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_en = 1'b1;
            tick();
            drive_en = 1'b0;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_tests++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL clr_mid_sda_out: got %b expected 1", sda_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_mid_busy: got %b expected 0", busy); end
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL clr_mid_ack: got %b expected 0", ack); end

        run_xfer(8'h3C, 1'b0, 1'b0, bits, ed, lp, bs, dn, ak, bn);
        n_tests++; if (bits !== {8'h3C, 1'b1}) begin n_fail++; $display("FAIL post_clr_bits: got %b expected %b", bits, {8'h3C, 1'b1}); end
        n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL post_clr_done: got %b expected 1", dn); end
    endtask

    task automatic test_basic();
        logic [W:0] bits;
        int ed;
        logic lp, bs, dn, ak, bn;
        run_xfer(8'hA5, 1'b0, 1'b0, bits, ed, lp, bs, dn, ak, bn);
        n_tests++; if (lp !== 1'b1) begin n_fail++; $display("FAIL basic_line_after_load: got %b expected 1", lp); end
        n_tests++; if (bs !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_load: got %b expected 1", bs); end
        n_tests++; if (bits !== 9'b1010_0101_1) begin n_fail++; $display("FAIL basic_bits: got %b expected 101001011", bits); end
        n_tests++; if (ed !== 0) begin n_fail++; $display("FAIL basic_early_done: got %0d expected 0", ed); end
        n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", dn); end
        n_tests++; if (ak !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b expected 1", ak); end
        n_tests++; if (bn !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done: got %b expected 0", bn); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b expected 0", done); end
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack_hold: got %b expected 1", ack); end
    endtask

    task automatic test_nak();
        logic [W:0] bits;
        int ed;
        logic lp, bs, dn, ak, bn;
        run_xfer(8'hFF, 1'b1, 1'b0, bits, ed, lp, bs, dn, ak, bn);
        n_tests++; if (bits !== 9'h1FF) begin n_fail++; $display("FAIL nak_bits: got %b expected 111111111", bits); end
        n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL nak_done: got %b expected 1", dn); end
        n_tests++; if (ak !== 1'b0) begin n_fail++; $display("FAIL nak_ack: got %b expected 0", ak); end
    endtask

    task automatic test_back_to_back();
        logic [W:0] bits;
        logic [W-1:0] d0;
        int ed;
        logic lp, bs, dn, ak, bn;
        d0 = W'($urandom);
        run_xfer(d0, 1'b0, 1'b0, bits, ed, lp, bs, dn, ak, bn);
        n_tests++; if (bits !== {d0, 1'b1}) begin n_fail++; $display("FAIL b2b_first_bits: got %b expected %b", bits, {d0, 1'b1}); end
        data = 8'h81;
        load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_load_in_done: got %b expected 1", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
        run_xfer(8'h81, 1'b1, 1'b1, bits, ed, lp, bs, dn, ak, bn);
        n_tests++; if (bits !== 9'b1000_0001_1) begin n_fail++; $display("FAIL b2b_second_bits: got %b expected 100000011", bits); end
        n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1", dn); end
        n_tests++; if (ak !== 1'b0) begin n_fail++; $display("FAIL b2b_second_ack: got %b expected 0", ak); end
    endtask

    task automatic test_simultaneous();
        data = 8'hC3;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i <= W; i++) begin
            drive_en = 1'b1;
            tick();
            drive_en = 1'b0;
        end
        sda_in    = 1'b0;
        drive_en  = 1'b1;
        sample_en = 1'b1;
        tick();
        drive_en  = 1'b0;
        sample_en = 1'b0;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL simul_no_done: got %b expected 0", done); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_still_busy: got %b expected 1", busy); end
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL simul_ack_unchanged: got %b expected 0", ack); end
        tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        sda_in    = 1'b1;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL simul_lone_sample_done: got %b expected 1", done); end
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL simul_lone_sample_ack: got %b expected 1", ack); end
        tick();
    endtask

    task automatic test_arbitration();
        logic ack_before;
        ack_before = ack;
        data = 8'hFF;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int s = 0; s < 2; s++) begin
            drive_en = 1'b1;
            tick();
            drive_en = 1'b0;
            sda_in    = (s == 1) ? 1'b0 : 1'b1;
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            sda_in    = 1'b1;
        end
`ifdef SERIAL_TX_ARB_LOST_EN
        n_tests++; if (arb_lost !== 1'b1) begin n_fail++; $display("FAIL arb_pulse: got %b expected 1", arb_lost); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arb_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL arb_no_done: got %b expected 0", done); end
        n_tests++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL arb_sda_out: got %b expected 1", sda_out); end
        n_tests++; if (ack !== ack_before) begin n_fail++; $display("FAIL arb_ack_kept: got %b expected %b", ack, ack_before); end
        tick();
        n_tests++; if (arb_lost !== 1'b0) begin n_fail++; $display("FAIL arb_pulse_width: got %b expected 0", arb_lost); end
`else
        n_tests++; if (arb_lost !== 1'b0) begin n_fail++; $display("FAIL arb_tied_low: got %b expected 0", arb_lost); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arb_off_busy: got %b expected 1", busy); end
        n_tests++; if (ack !== ack_before) begin n_fail++; $display("FAIL arb_off_ack_kept: got %b expected %b", ack, ack_before); end
        for (int i = 0; i < W - 1; i++) begin
            drive_en = 1'b1;
            tick();
            drive_en = 1'b0;
        end
        sda_in    = 1'b0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        sda_in    = 1'b1;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL arb_off_done: got %b expected 1", done); end
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL arb_off_ack: got %b expected 1", ack); end
        tick();
`endif
    endtask

    task automatic test_random();
        logic [W:0] bits;
        logic [W-1:0] d;
        logic a;
        int ed;
        logic lp, bs, dn, ak, bn;
        for (int k = 0; k < 24; k++) begin
            d = W'($urandom);
            a = ($urandom_range(0, 1) == 1);
            run_xfer(d, a, 1'b0, bits, ed, lp, bs, dn, ak, bn);
            n_tests++; if (bits !== {d, 1'b1}) begin n_fail++; $display("FAIL rand_bits[%0d]: got %b expected %b", k, bits, {d, 1'b1}); end
            n_tests++; if (ed !== 0 || dn !== 1'b1) begin n_fail++; $display("FAIL rand_done[%0d]: got early=%0d done=%b expected early=0 done=1", k, ed, dn); end
            n_tests++; if (ak !== ~a) begin n_fail++; $display("FAIL rand_ack[%0d]: got %b expected %b", k, ak, ~a); end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nak();
        test_back_to_back();
        test_simultaneous();
        test_arbitration();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
